count_sequencer: RTL and testbench
==================================

// Module: count_sequencer
// PURPOSE
//  Sequences a WIDTH-bit modular up-counter through programmed passes: 0..limit, repeated reps+1 times.
//  Provides start/done handshake, hold (freeze) and abort, and a terminal-count strobe.
//  Sits between control logic and the counter datapath; q drives downstream decode.
// PARAMETERS
//  WIDTH   3  counter width; q counts 0..limit, limit <= 2**WIDTH-1
//  RWIDTH  4  pass-counter width; passes = reps+1 (1..2**RWIDTH)
// PORTS
//  c      in   1       clock; all state changes on rising edge
//  rn     in   1       reset, synchronous, active-low
//  start  in   1       begin sequence; sampled only in IDLE
//  limit  in   WIDTH   terminal value of q; latched on accepted start
//  reps   in   RWIDTH  extra passes; latched on accepted start
//  hold   in   1       freeze q and pass count while in RUN
//  abort  in   1       cancel RUN or DONE, return to IDLE
//  ack    in   1       done acknowledge; sampled only in DONE
//  q      out  WIDTH   current count (binary, or Gray if SEQ_GRAY_EN)
//  pass   out  RWIDTH  index of current pass, 0-based
//  tc     out  1       terminal count: RUN && q==limit_l && !hold (combinational from regs+hold)
//  busy   out  1       1 in RUN
//  done   out  1       1 in DONE
// BEHAVIOUR
//  Reset (rn=0 at an edge): state=IDLE, q=0, pass=0, limit_l=0, reps_l=0, busy=0, done=0, tc=0.
//  States: IDLE, RUN, DONE (2-bit encoded register). All outputs except tc are registered.
//  IDLE:  q=0, pass=0. start=1 at edge -> latch limit_l/reps_l; RUN next cycle with q=0, pass=0.
//  RUN, priority abort > hold > count:
//   abort=1 -> IDLE, q=0, pass=0; done never asserts.
//   hold=1  -> all registers unchanged; tc=0.
//   q<limit_l -> q+1.
//   q==limit_l, pass<reps_l -> q=0, pass+1 (wrap).
//   q==limit_l, pass==reps_l -> DONE, q=0, pass=0.
//  Latency: exactly (limit_l+1)*(reps_l+1) non-held RUN cycles from start accept to done=1.
//  limit=0: tc high on every non-held RUN cycle; q stays 0.
//  reps=0: single pass. limit/reps changes during RUN are ignored (latched copies used).
//  DONE:  done=1, q=0. ack=1 or abort=1 -> IDLE next edge. start ignored in DONE,
//   including start with ack in the same cycle; start must be resampled in IDLE.
//  start held high continuously: a new sequence begins the cycle after DONE->IDLE.
//  Reset overrides everything, including mid-pass and DONE.
//  No arithmetic overflow: q never exceeds limit_l; pass never exceeds reps_l.
// CONFIGURATION
//  SEQ_GRAY_EN defined: q output = qb ^ (qb >> 1), where qb is the internal binary count.
//   tc and all comparisons use qb. Gray q changes one bit per step, including the wrap
//   when limit_l = 2**WIDTH-1.
//  SEQ_GRAY_EN undefined: q = qb (plain binary). No other behavioural difference.
// TESTING
//  1. Reset: rn=0 for 2 edges with start=1 -> q=0, pass=0, busy=0, done=0, tc=0.
//     After rn=1, RUN begins on the following edge.
//  2. limit=3, reps=1, start pulse -> q=0,1,2,3,0,1,2,3 with pass 0 then 1; tc at both q=3.
//     done=1 on the 9th cycle after accept; ack -> IDLE.
//  3. limit=5, reps=0, hold=1 for 3 cycles at q=2 -> q stays 2, tc=0 while held.
//     done arrives 3 cycles late (9 cycles after accept).
//  4. limit=7, reps=2, abort at pass=1, q=4 -> IDLE next edge, q=0, busy=0, done never 1.
//     Also: abort+hold in the same cycle -> abort wins.
//  5. limit=0, reps=3 -> tc high for 4 consecutive cycles, q=0 throughout, then done=1.
//     In DONE, start+ack together -> IDLE, no restart until start is resampled.
//  6. SEQ_GRAY_EN, limit=7 -> q=000,001,011,010,110,111,101,100, then 000 at the wrap.
//     Exactly one bit changes per step.

Source files
------------

// File: rtl/count_sequencer.sv
// Pass sequencer for a WIDTH-bit up-counter: 0..limit, repeated reps+1 times.
// Define SEQ_GRAY_EN to present q Gray-coded; counting stays binary inside.
module count_sequencer #(
  parameter int WIDTH  = 3,
  parameter int RWIDTH = 4
) (
  input  logic              c,
  input  logic              rn,
  input  logic              start,
  input  logic [WIDTH-1:0]  limit,
  input  logic [RWIDTH-1:0] reps,
  input  logic              hold,
  input  logic              abort,
  input  logic              ack,
  output logic [WIDTH-1:0]  q,
  output logic [RWIDTH-1:0] pass,
  output logic              tc,
  output logic              busy,
  output logic              done
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic [WIDTH-1:0]  qb_q, qb_d;
  logic [WIDTH-1:0]  limit_q, limit_d;
  logic [RWIDTH-1:0] pass_q, pass_d;
  logic [RWIDTH-1:0] reps_q, reps_d;
  logic [WIDTH-1:0]  qo_q, qo_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;

  logic at_limit;
  logic last_pass;

  assign at_limit  = (qb_q == limit_q);
  assign last_pass = (pass_q == reps_q);

  // Next-state: IDLE waits for start, RUN counts (abort > hold > count), DONE waits for ack.
  always_comb begin
    state_d = state_q;
    qb_d    = qb_q;
    pass_d  = pass_q;
    limit_d = limit_q;
    reps_d  = reps_q;
    unique case (state_q)
      S_IDLE: begin
        qb_d   = '0;
        pass_d = '0;
        if (start) begin
          limit_d = limit;
          reps_d  = reps;
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        if (abort) begin
          qb_d    = '0;
          pass_d  = '0;
          state_d = S_IDLE;
        end else if (!hold) begin
          if (!at_limit) begin
            qb_d = qb_q + WIDTH'(1);
          end else if (!last_pass) begin
            qb_d   = '0;
            pass_d = pass_q + RWIDTH'(1);
          end else begin
            qb_d    = '0;
            pass_d  = '0;
            state_d = S_DONE;
          end
        end
      end
      S_DONE: begin
        qb_d   = '0;
        pass_d = '0;
        if (ack || abort) begin
          state_d = S_IDLE;
        end
      end
      default: begin
        qb_d    = '0;
        pass_d  = '0;
        state_d = S_IDLE;
      end
    endcase
  end

  // Registered output views derived from the next state.
  always_comb begin
    busy_d = (state_d == S_RUN);
    done_d = (state_d == S_DONE);
`ifdef SEQ_GRAY_EN
    qo_d   = qb_d ^ (qb_d >> 1);
`else
    qo_d   = qb_d;
`endif
  end

  // State and datapath registers with synchronous active-low reset.
  always_ff @(posedge c) begin
    if (!rn) begin
      state_q <= S_IDLE;
      qb_q    <= '0;
      pass_q  <= '0;
      limit_q <= '0;
      reps_q  <= '0;
      qo_q    <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      qb_q    <= qb_d;
      pass_q  <= pass_d;
      limit_q <= limit_d;
      reps_q  <= reps_d;
      qo_q    <= qo_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign q    = qo_q;
  assign pass = pass_q;
  assign busy = busy_q;
  assign done = done_q;
  assign tc   = (state_q == S_RUN) && at_limit && !hold;

endmodule

// File: tb/tb_count_sequencer.sv
// Self-checking bench for count_sequencer.
// Expected q/pass/tc come from the non-held cycle index k: q=k%(L+1), pass=k/(L+1).
module tb_count_sequencer;

  localparam int W  = 3;
  localparam int RW = 4;

  logic          c = 1'b0;
  logic          rn;
  logic          start;
  logic [W-1:0]  limit;
  logic [RW-1:0] reps;
  logic          hold;
  logic          abort;
  logic          ack;
  logic [W-1:0]  q;
  logic [RW-1:0] pass;
  logic          tc;
  logic          busy;
  logic          done;

  int n_vec = 0;
  int n_err = 0;

  count_sequencer #(.WIDTH(W), .RWIDTH(RW)) dut (
    .c(c), .rn(rn), .start(start), .limit(limit), .reps(reps),
    .hold(hold), .abort(abort), .ack(ack),
    .q(q), .pass(pass), .tc(tc), .busy(busy), .done(done)
  );

  always #5 c = ~c;

  function automatic logic [W-1:0] enc(input int b);
    logic [W-1:0] v;
    v = W'(b);
`ifdef SEQ_GRAY_EN
    return v ^ (v >> 1);
`else
    return v;
`endif
  endfunction

  task automatic run_seq(input int L, input int R, input int hpct,
                         input int hk, input int hn, input int ak,
                         input bit ahold, input int lat);
    int total;
    int k;
    int cyc;
    int hleft;
    bit h;
    bit ab;
    bit aborted;
    logic [W+RW+2:0] exp_v;
    logic [W+RW+2:0] act_v;
`ifdef SEQ_GRAY_EN
    logic [W-1:0] prev_q;
    bit prev_h;
    prev_q = '0;
    prev_h = 1'b1;
`endif
    total = (L + 1) * (R + 1);
    k = 0;
    cyc = 0;
    hleft = hn;
    aborted = 0;
    @(negedge c);
    start = 1; limit = W'(L); reps = RW'(R);
    hold = 0; abort = 0; ack = 0;
    #1;
    n_vec++;
    if ({busy, done} !== 2'b00) begin
      n_err++;
      $display("FAIL accept_idle busy/done=%b%b want 00", busy, done);
    end
    @(negedge c);
    start = 0;
    while (!aborted && k < total && cyc < 2000) begin
      limit = W'($urandom);
      reps = RW'($urandom);
      ab = (k == ak);
      h = 0;
      if (hpct > 0 && $urandom_range(99) < hpct) h = 1;
      if (k == hk && hleft > 0) begin
        h = 1;
        hleft--;
      end
      if (ab && ahold) h = 1;
      hold = h;
      abort = ab;
      #1;
      exp_v = {1'b1, 1'b0, enc(k % (L + 1)), RW'(k / (L + 1)),
               (k % (L + 1) == L) && !h};
      act_v = {busy, done, q, pass, tc};
      n_vec++;
      if (act_v !== exp_v) begin
        n_err++;
        $display("FAIL run L%0d R%0d k%0d {busy,done,q,pass,tc} got %b want %b",
                 L, R, k, act_v, exp_v);
      end
`ifdef SEQ_GRAY_EN
      if (L == 7 && cyc > 0 && !prev_h) begin
        n_vec++;
        if ($countones(q ^ prev_q) != 1) begin
          n_err++;
          $display("FAIL gray_step k%0d q %b prev %b", k, q, prev_q);
        end
      end
      prev_q = q;
      prev_h = h;
`endif
      cyc++;
      if (ab) aborted = 1;
      else if (!h) k++;
      @(negedge c);
    end
    hold = 0;
    abort = 0;
    #1;
    n_vec++;
    if (cyc >= 2000) begin
      n_err++;
      $display("FAIL timeout L%0d R%0d cycles %0d", L, R, cyc);
    end else if (aborted) begin
      act_v = {busy, done, q, pass, tc};
      if (act_v !== '0) begin
        n_err++;
        $display("FAIL abort_idle got %b want 0", act_v);
      end
      for (int i = 0; i < 3; i++) begin
        @(negedge c);
        #1;
        n_vec++;
        if ({busy, done} !== 2'b00) begin
          n_err++;
          $display("FAIL abort_stay busy/done=%b%b want 00", busy, done);
        end
      end
    end else begin
      act_v = {busy, done, q, pass, tc};
      exp_v = {1'b0, 1'b1, {W{1'b0}}, {RW{1'b0}}, 1'b0};
      if (act_v !== exp_v) begin
        n_err++;
        $display("FAIL done L%0d R%0d got %b want %b", L, R, act_v, exp_v);
      end
      if (lat > 0) begin
        n_vec++;
        if (cyc != lat) begin
          n_err++;
          $display("FAIL latency got %0d want %0d", cyc, lat);
        end
      end
    end
  endtask

  task automatic finish_ack();
    @(negedge c);
    ack = 1;
    #1;
    n_vec++;
    if (done !== 1'b1) begin
      n_err++;
      $display("FAIL ack_pre done=%b want 1", done);
    end
    @(negedge c);
    ack = 0;
    #1;
    n_vec++;
    if ({busy, done, q, pass} !== '0) begin
      n_err++;
      $display("FAIL ack_idle got %b want 0", {busy, done, q, pass});
    end
  endtask

  task automatic test_reset();
    rn = 0; start = 1; limit = 3'd3; reps = 4'd1;
    hold = 0; abort = 0; ack = 0;
    for (int i = 0; i < 2; i++) begin
      @(negedge c);
      #1;
      n_vec++;
      if ({busy, done, q, pass, tc} !== '0) begin
        n_err++;
        $display("FAIL reset cyc%0d got %b want 0", i, {busy, done, q, pass, tc});
      end
    end
    rn = 1;
    @(negedge c);
    #1;
    n_vec++;
    if ({busy, done, q, pass} !== {1'b1, 1'b0, {W{1'b0}}, {RW{1'b0}}}) begin
      n_err++;
      $display("FAIL reset_release got %b want run q0 p0", {busy, done, q, pass});
    end
    start = 0;
    abort = 1;
    @(negedge c);
    abort = 0;
    #1;
    n_vec++;
    if (busy !== 1'b0) begin
      n_err++;
      $display("FAIL reset_cleanup busy=%b want 0", busy);
    end
  endtask

  task automatic test_reset_mid();
    @(negedge c);
    start = 1; limit = 3'd5; reps = 4'd2;
    @(negedge c);
    start = 0;
    repeat (4) @(negedge c);
    rn = 0;
    @(negedge c);
    #1;
    n_vec++;
    if ({busy, done, q, pass, tc} !== '0) begin
      n_err++;
      $display("FAIL reset_mid got %b want 0", {busy, done, q, pass, tc});
    end
    rn = 1;
  endtask

  task automatic test_two_pass();
    run_seq(3, 1, 0, -1, 0, -1, 0, 8);
    finish_ack();
  endtask

  task automatic test_hold();
    run_seq(5, 0, 0, 2, 3, -1, 0, 9);
    finish_ack();
  endtask

  task automatic test_abort();
    run_seq(7, 2, 0, -1, 0, 12, 0, 0);
    run_seq(7, 2, 0, -1, 0, 5, 1, 0);
  endtask

  task automatic test_limit_zero();
    run_seq(0, 3, 0, -1, 0, -1, 0, 4);
    @(negedge c);
    start = 1;
    ack = 1;
    #1;
    n_vec++;
    if (done !== 1'b1) begin
      n_err++;
      $display("FAIL start_ack_pre done=%b want 1", done);
    end
    @(negedge c);
    start = 0;
    ack = 0;
    for (int i = 0; i < 2; i++) begin
      #1;
      n_vec++;
      if ({busy, done} !== 2'b00) begin
        n_err++;
        $display("FAIL start_ack_norestart cyc%0d busy/done=%b%b want 00",
                 i, busy, done);
      end
      @(negedge c);
    end
  endtask

  task automatic test_start_held();
    run_seq(2, 0, 0, -1, 0, -1, 0, 3);
    @(negedge c);
    start = 1;
    ack = 1;
    @(negedge c);
    ack = 0;
    #1;
    n_vec++;
    if ({busy, done} !== 2'b00) begin
      n_err++;
      $display("FAIL held_start_idle busy/done=%b%b want 00", busy, done);
    end
    @(negedge c);
    #1;
    n_vec++;
    if ({busy, done, q, pass} !== {1'b1, 1'b0, {W{1'b0}}, {RW{1'b0}}}) begin
      n_err++;
      $display("FAIL held_start_run got %b want run q0 p0", {busy, done, q, pass});
    end
    @(negedge c);
    start = 0;
    abort = 1;
    @(negedge c);
    abort = 0;
  endtask

  task automatic test_abort_done();
    run_seq(1, 1, 0, -1, 0, -1, 0, 4);
    @(negedge c);
    abort = 1;
    @(negedge c);
    abort = 0;
    #1;
    n_vec++;
    if ({busy, done} !== 2'b00) begin
      n_err++;
      $display("FAIL abort_done busy/done=%b%b want 00", busy, done);
    end
  endtask

  task automatic test_gray_wrap();
    run_seq(7, 1, 0, -1, 0, -1, 0, 16);
    finish_ack();
  endtask

  task automatic test_random();
    int L;
    int R;
    int ak;
    for (int it = 0; it < 16; it++) begin
      L = int'($urandom_range(7));
      R = int'($urandom_range(15));
      ak = -1;
      if ($urandom_range(3) == 0)
        ak = int'($urandom_range((L + 1) * (R + 1) - 1));
      run_seq(L, R, 25, -1, 0, ak, 1'($urandom_range(1)), 0);
      if (ak < 0) finish_ack();
    end
  endtask

  initial begin
    test_reset();
    test_reset_mid();
    test_two_pass();
    test_hold();
    test_abort();
    test_limit_zero();
    test_start_held();
    test_abort_done();
    test_gray_wrap();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
